smz_scrub_ctrl: RTL and testbench
=================================

// Module: smz_scrub_ctrl
// PURPOSE
//  Owns the SMZ config registers (base/size/enable) and drives them to smz_layer.
//  Runs a scrub engine that writes zero plaintext to every word of the secure region, so the region holds freshly encrypted zeros.
//  Arbitrates the single memory port in front of smz_layer between CPU traffic and scrub writes.
// PARAMETERS
//  RESET_BASE   32'h0000_8000  smz_base reset value (word aligned)
//  RESET_SIZE   32'h0000_1000  smz_size reset value in bytes (word aligned)
// PORTS
//  clk            in   1   single clock, all logic rising-edge
//  resetn         in   1   asynchronous active-low reset
//  cfg_we         in   1   config register write strobe, one cycle
//  cfg_addr       in   2   0=BASE 1=SIZE 2=CTRL 3=STATUS
//  cfg_wdata      in   32  config write data
//  cfg_rdata      out  32  combinational readback of cfg_addr
//  cpu_mem_valid  in   1   CPU request
//  cpu_mem_addr   in   32  CPU address
//  cpu_mem_wdata  in   32  CPU write data
//  cpu_mem_wstrb  in   4   CPU byte strobes; 0 = read
//  cpu_mem_ready  out  1   CPU transfer complete
//  cpu_mem_rdata  out  32  = mem_rdata, passthrough
//  mem_valid      out  1   request to smz_layer/memory
//  mem_addr       out  32  granted address
//  mem_wdata      out  32  granted write data
//  mem_wstrb      out  4   granted strobes
//  mem_ready      in   1   memory transfer complete
//  mem_rdata      in   32  memory read data (already decrypted by smz_layer)
//  smz_base       out  32  to smz_layer
//  smz_size       out  32  to smz_layer
//  smz_enable     out  1   to smz_layer
//  irq_done       out  1   one-cycle pulse when a scrub completes
// BEHAVIOUR
//  Reset values: smz_base=RESET_BASE, smz_size=RESET_SIZE, smz_enable=0, mem_valid=0, mem_addr/wdata/wstrb=0, cpu_mem_ready=0, irq_done=0, STATUS=0. Scrub FSM=S_IDLE, arb FSM=A_IDLE.
//  Config writes take effect the cycle after cfg_we. BASE and SIZE bits[1:0] are forced to 0.
//  CTRL: [0] enable (R/W), [1] start (write 1 starts scrub, self-clearing, reads 0).
//  STATUS: [0] busy (RO), [1] done (sticky), [2] cfg_err (sticky). Any STATUS write clears [2:1]. A start also clears done.
//  While busy: writes to BASE, SIZE and CTRL.enable are dropped and set cfg_err. A start while busy is ignored and sets cfg_err.
//  If a single CTRL write sets enable and start, both apply; scrub uses the post-write config.
//  Scrub FSM: S_IDLE -start-> S_RUN (ptr=base, end=base+size as 33-bit, end clipped to 2^32).
//   S_RUN issues wstrb=4'hF, wdata=0 at ptr. On each accepted beat ptr+=4; when ptr>=end -> S_DONE.
//   size=0 goes S_RUN->S_DONE with no memory beats.
//   S_DONE: irq_done=1 and done set for exactly one cycle -> S_IDLE.
//   busy = (state != S_IDLE).
//  Arbiter:
//   A_IDLE picks an owner, then registers mem_* next cycle in A_CPU or A_SCRUB.
//   mem_* hold stable with mem_valid=1 until mem_ready, then return to A_IDLE with mem_valid=0 the following cycle. Minimum 1 idle cycle between beats.
//  Priority: CPU wins over scrub, except CPU accesses inside [smz_base, smz_base+smz_size) are not granted while busy. They stall (cpu_mem_ready=0) until the scrub finishes.
//  cpu_mem_ready = mem_ready & (owner==CPU). Never asserted for scrub beats.
//  In-region test uses the same 33-bit compare as the scrub end. It is evaluated at grant time.
//  smz_enable is not required for a scrub; with enable=0 the region is zeroed in plaintext.
//  Reset mid-scrub or mid-beat: everything returns to reset values. The scrub is abandoned and done is not set.
// STRUCTURE
//  smz_pkg: register offsets, CTRL/STATUS bit indices, scrub and arbiter state encodings.
//  Sub-module smz_arb: 2-requester arbiter with the A_IDLE/A_CPU/A_SCRUB FSM and registered mem_* outputs.
//  Config registers, in-region compare and scrub FSM stay in smz_scrub_ctrl.
// TESTING
//  Reset, read all cfg regs -> BASE=RESET_BASE, SIZE=RESET_SIZE, CTRL=0, STATUS=0.
//  BASE=0x100, SIZE=0x10, CTRL=0x3, mem_ready always 1 -> 4 writes of 0 to 0x100,0x104,0x108,0x10C, then one irq_done, STATUS=0x2.
//  SIZE=0, start -> no mem_valid, irq_done 2 cycles after the write, done=1.
//  Scrub 0x100/0x40 with CPU read at 0x2000 mid-scrub -> CPU granted next A_IDLE. CPU read at 0x120 stalls until irq_done, then completes.
//  Write BASE=0x500 while busy -> smz_base unchanged, cfg_err=1. STATUS write clears it.
//  BASE=0xFFFF_FFF8, SIZE=0x10 -> exactly 2 beats (0x...F8, 0x...FC), no wrap to 0. Reset asserted mid-beat -> mem_valid=0 immediately, STATUS=0.

Source files
------------

// File: rtl/smz_pkg.sv
// Shared definitions for the SMZ scrub controller: register map, bit indices,
// FSM state encodings and the 33-bit region-end helper.
package smz_pkg;

    localparam logic [1:0] REG_BASE   = 2'd0;
    localparam logic [1:0] REG_SIZE   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_START = 1;

    localparam int unsigned ST_BUSY = 0;
    localparam int unsigned ST_DONE = 1;
    localparam int unsigned ST_ERR  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } scrub_state_t;

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_CPU   = 2'd1,
        A_SCRUB = 2'd2
    } arb_state_t;

    // Exclusive end of the region, computed without wrap and clipped to 2^32.
    function automatic logic [32:0] region_end(input logic [31:0] base,
                                               input logic [31:0] size);
        logic [32:0] sum;
        sum = {1'b0, base} + {1'b0, size};
        return (sum > 33'h1_0000_0000) ? 33'h1_0000_0000 : sum;
    endfunction

endpackage

// File: rtl/smz_arb.sv
// Two-requester arbiter (CPU over scrub) for the single memory port, with
// registered mem_* outputs held stable until mem_ready.
module smz_arb
    import smz_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    input  logic        scr_req,
    input  logic [31:0] scr_addr,
    output logic        cpu_ready,
    output logic        scr_ack,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready
);

    arb_state_t  state, state_nx;
    logic        valid_nx;
    logic [31:0] addr_nx;
    logic [31:0] wdata_nx;
    logic [3:0]  wstrb_nx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= A_IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            state     <= state_nx;
            mem_valid <= valid_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            mem_wstrb <= wstrb_nx;
        end
    end

    always_comb begin
        state_nx = state;
        valid_nx = mem_valid;
        addr_nx  = mem_addr;
        wdata_nx = mem_wdata;
        wstrb_nx = mem_wstrb;
        case (state)
            A_IDLE: begin
                if (cpu_req) begin
                    state_nx = A_CPU;
                    valid_nx = 1'b1;
                    addr_nx  = cpu_addr;
                    wdata_nx = cpu_wdata;
                    wstrb_nx = cpu_wstrb;
                end else if (scr_req) begin
                    state_nx = A_SCRUB;
                    valid_nx = 1'b1;
                    addr_nx  = scr_addr;
                    wdata_nx = '0;
                    wstrb_nx = '1;
                end
            end
            A_CPU, A_SCRUB: begin
                if (mem_ready) begin
                    state_nx = A_IDLE;
                    valid_nx = 1'b0;
                end
            end
            default: begin
                state_nx = A_IDLE;
                valid_nx = 1'b0;
            end
        endcase
    end

    assign cpu_ready = mem_ready & (state == A_CPU);
    assign scr_ack   = mem_ready & (state == A_SCRUB);

endmodule

// File: rtl/smz_scrub_ctrl.sv
// SMZ config registers, scrub engine that zero-fills the secure region, and
// CPU/scrub sharing of the memory port in front of smz_layer.
module smz_scrub_ctrl
    import smz_pkg::*;
#(
    parameter logic [31:0] RESET_BASE = 32'h0000_8000,
    parameter logic [31:0] RESET_SIZE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    input  logic        cpu_mem_valid,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] smz_base,
    output logic [31:0] smz_size,
    output logic        smz_enable,
    output logic        irq_done
);

    scrub_state_t state, state_nx;
    logic [32:0]  ptr;
    logic [32:0]  end_q;
    logic         done_q;
    logic         err_q;
    logic         busy;
    logic         start_ok;
    logic         scr_req;
    logic         scr_ack;
    logic         in_region;
    logic         cpu_req;

    assign busy     = (state != S_IDLE);
    assign start_ok = cfg_we && (cfg_addr == REG_CTRL) && cfg_wdata[CTRL_START] && !busy;

    // In-region CPU accesses wait until the scrub has fully finished.
    assign in_region = ({1'b0, cpu_mem_addr} >= {1'b0, smz_base}) &&
                       ({1'b0, cpu_mem_addr} <  region_end(smz_base, smz_size));
    assign cpu_req   = cpu_mem_valid && !(busy && in_region);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            ptr        <= '0;
            end_q      <= '0;
            smz_base   <= RESET_BASE;
            smz_size   <= RESET_SIZE;
            smz_enable <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                ptr   <= {1'b0, smz_base};
                end_q <= region_end(smz_base, smz_size);
            end else if (scr_ack) begin
                ptr <= ptr + 33'd4;
            end
            if (cfg_we) begin
                case (cfg_addr)
                    REG_BASE: begin
                        if (busy) err_q <= 1'b1;
                        else      smz_base <= {cfg_wdata[31:2], 2'b00};
                    end
                    REG_SIZE: begin
                        if (busy) err_q <= 1'b1;
                        else      smz_size <= {cfg_wdata[31:2], 2'b00};
                    end
                    REG_CTRL: begin
                        if (busy) begin
                            err_q <= 1'b1;
                        end else begin
                            smz_enable <= cfg_wdata[CTRL_EN];
                            if (cfg_wdata[CTRL_START]) done_q <= 1'b0;
                        end
                    end
                    default: begin
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                    end
                endcase
            end
            // Completion wins over a same-cycle STATUS clear so it is never lost.
            if (state == S_DONE) done_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        scr_req  = 1'b0;
        irq_done = 1'b0;
        case (state)
            S_IDLE: if (start_ok) state_nx = S_RUN;
            S_RUN: begin
                if (ptr >= end_q) state_nx = S_DONE;
                else              scr_req  = 1'b1;
            end
            S_DONE: begin
                irq_done = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_BASE: cfg_rdata = smz_base;
            REG_SIZE: cfg_rdata = smz_size;
            REG_CTRL: cfg_rdata[CTRL_EN] = smz_enable;
            default: begin
                cfg_rdata[ST_BUSY] = busy;
                cfg_rdata[ST_DONE] = done_q;
                cfg_rdata[ST_ERR]  = err_q;
            end
        endcase
    end

    smz_arb u_arb (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_mem_addr),
        .cpu_wdata (cpu_mem_wdata),
        .cpu_wstrb (cpu_mem_wstrb),
        .scr_req   (scr_req),
        .scr_addr  (ptr[31:0]),
        .cpu_ready (cpu_mem_ready),
        .scr_ack   (scr_ack),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready)
    );

    assign cpu_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_smz_scrub_ctrl.sv
// Directed bench for smz_scrub_ctrl: register reset/readback, scrub beats,
// zero-size scrub, CPU arbitration and stall, busy write errors, top-of-memory clip, reset mid-beat.
module tb_smz_scrub_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        cpu_mem_valid;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_rdata;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] smz_base;
    logic [31:0] smz_size;
    logic        smz_enable;
    logic        irq_done;

    int checks = 0;
    int errors = 0;
    int irq_cnt = 0;
    int valid_cnt = 0;
    logic [31:0] beat_addr[$];
    logic [31:0] beat_wdata[$];
    logic [3:0]  beat_strb[$];

    always #5 clk = ~clk;

    smz_scrub_ctrl #(.RESET_BASE(32'h0000_8000), .RESET_SIZE(32'h0000_1000)) dut (
        .clk(clk), .resetn(resetn),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_ready(cpu_mem_ready), .cpu_mem_rdata(cpu_mem_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .smz_base(smz_base), .smz_size(smz_size), .smz_enable(smz_enable), .irq_done(irq_done)
    );

    always @(negedge clk) begin
        if (resetn && mem_valid && mem_ready) begin
            beat_addr.push_back(mem_addr);
            beat_wdata.push_back(mem_wdata);
            beat_strb.push_back(mem_wstrb);
        end
        if (mem_valid) valid_cnt++;
        if (irq_done) irq_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0; cfg_addr = 2'd3;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic wait_irq(input int max_cycles, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (irq_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_beats();
        beat_addr.delete();
        beat_wdata.delete();
        beat_strb.delete();
    endtask

    initial begin
        logic [31:0] rd;
        logic        ok;
        logic        seen_irq;
        int          lat;
        int          irq_before;
        int          v_before;
        int          nscrub;

        resetn = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        cpu_mem_valid = 1'b0; cpu_mem_addr = '0; cpu_mem_wdata = '0; cpu_mem_wstrb = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_irq", {31'b0, irq_done}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        cfg_read(2'd0, rd); check("rst_base", rd, 32'h0000_8000);
        cfg_read(2'd1, rd); check("rst_size", rd, 32'h0000_1000);
        cfg_read(2'd2, rd); check("rst_ctrl", rd, 32'd0);
        cfg_read(2'd3, rd); check("rst_status", rd, 32'd0);
        check("rst_smz_enable", {31'b0, smz_enable}, 32'd0);
        check("rst_cpu_ready", {31'b0, cpu_mem_ready}, 32'd0);

        // Basic 4-word scrub with memory always ready
        mem_ready = 1'b1;
        clear_beats();
        cfg_write(2'd0, 32'h0000_0103);
        cfg_write(2'd1, 32'h0000_0010);
        irq_before = irq_cnt;
        cfg_write(2'd2, 32'h0000_0003);
        wait_irq(100, ok);
        check("s1_irq_seen", {31'b0, ok}, 32'd1);
        repeat (3) @(negedge clk);
        check("s1_beats", beat_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("s1_addr", (i < beat_addr.size()) ? beat_addr[i] : 32'hDEAD_DEAD, 32'h100 + 32'(4 * i));
            check("s1_wdata", (i < beat_wdata.size()) ? beat_wdata[i] : 32'hDEAD_DEAD, 32'd0);
            check("s1_wstrb", (i < beat_strb.size()) ? {28'b0, beat_strb[i]} : 32'hDEAD_DEAD, 32'hF);
        end
        check("s1_irq_count", irq_cnt - irq_before, 32'd1);
        cfg_read(2'd3, rd); check("s1_status", rd, 32'h2);
        cfg_read(2'd2, rd); check("s1_ctrl", rd, 32'h1);
        check("s1_smz_base", smz_base, 32'h100);
        check("s1_smz_enable", {31'b0, smz_enable}, 32'd1);

        // Zero-size scrub
        cfg_write(2'd3, 32'd0);
        cfg_read(2'd3, rd); check("s2_status_clr", rd, 32'd0);
        cfg_write(2'd1, 32'd0);
        v_before = valid_cnt;
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h3;
        @(negedge clk);
        cfg_we = 1'b0; cfg_addr = 2'd3;
        check("s2_irq_early", {31'b0, irq_done}, 32'd0);
        @(negedge clk);
        check("s2_irq_pulse", {31'b0, irq_done}, 32'd1);
        @(negedge clk);
        check("s2_irq_end", {31'b0, irq_done}, 32'd0);
        cfg_read(2'd3, rd); check("s2_status", rd, 32'h2);
        check("s2_no_valid", valid_cnt - v_before, 32'd0);

        // CPU traffic during a scrub of 0x100/0x40
        cfg_write(2'd3, 32'd0);
        cfg_write(2'd1, 32'h40);
        mem_rdata = 32'hCAFE_0001;
        clear_beats();
        cfg_write(2'd2, 32'h3);
        repeat (3) @(negedge clk);
        cpu_mem_valid = 1'b1; cpu_mem_addr = 32'h2000; cpu_mem_wstrb = 4'h0;
        ok = 1'b0; lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (cpu_mem_ready) begin ok = 1'b1; break; end
        end
        check("s3_cpu_out_ready", {31'b0, ok}, 32'd1);
        check("s3_cpu_out_lat_le2", {31'b0, (lat <= 2)}, 32'd1);
        check("s3_cpu_out_addr", mem_addr, 32'h2000);
        check("s3_cpu_out_wstrb", {28'b0, mem_wstrb}, 32'd0);
        check("s3_cpu_rdata", cpu_mem_rdata, 32'hCAFE_0001);
        cfg_read(2'd3, rd); check("s3_busy_at_grant", rd & 32'h1, 32'h1);
        cpu_mem_valid = 1'b0;
        @(negedge clk);
        cpu_mem_valid = 1'b1; cpu_mem_addr = 32'h120;
        ok = 1'b0; seen_irq = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (irq_done) seen_irq = 1'b1;
            if (cpu_mem_ready) begin ok = 1'b1; break; end
        end
        check("s3_cpu_in_ready", {31'b0, ok}, 32'd1);
        check("s3_cpu_in_after_irq", {31'b0, seen_irq}, 32'd1);
        check("s3_cpu_in_addr", mem_addr, 32'h120);
        cpu_mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        nscrub = 0;
        foreach (beat_strb[i]) if (beat_strb[i] == 4'hF) nscrub++;
        check("s3_scrub_beats", nscrub, 32'd16);

        // Config writes while busy
        cfg_write(2'd3, 32'd0);
        cfg_write(2'd2, 32'h3);
        cfg_write(2'd0, 32'h500);
        check("s4_base_kept", smz_base, 32'h100);
        cfg_read(2'd3, rd); check("s4_err_set", rd & 32'h4, 32'h4);
        wait_irq(200, ok);
        check("s4_irq_seen", {31'b0, ok}, 32'd1);
        repeat (2) @(negedge clk);
        cfg_read(2'd3, rd); check("s4_status_done_err", rd, 32'h6);
        cfg_write(2'd3, 32'd0);
        cfg_read(2'd3, rd); check("s4_status_clr", rd, 32'd0);

        // Top-of-address-space region, clipped end
        cfg_write(2'd0, 32'hFFFF_FFF8);
        cfg_write(2'd1, 32'h10);
        clear_beats();
        cfg_write(2'd2, 32'h3);
        wait_irq(100, ok);
        check("s5_irq_seen", {31'b0, ok}, 32'd1);
        repeat (3) @(negedge clk);
        check("s5_beats", beat_addr.size(), 32'd2);
        check("s5_addr0", (beat_addr.size() > 0) ? beat_addr[0] : 32'hDEAD_DEAD, 32'hFFFF_FFF8);
        check("s5_addr1", (beat_addr.size() > 1) ? beat_addr[1] : 32'hDEAD_DEAD, 32'hFFFF_FFFC);

        // Reset in the middle of a held beat
        cfg_write(2'd3, 32'd0);
        mem_ready = 1'b0;
        cfg_write(2'd2, 32'h3);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_valid) begin ok = 1'b1; break; end
        end
        check("s6_beat_pending", {31'b0, ok}, 32'd1);
        irq_before = irq_cnt;
        resetn = 1'b0;
        #1;
        check("s6_valid_drop", {31'b0, mem_valid}, 32'd0);
        cfg_read(2'd3, rd); check("s6_status_rst", rd, 32'd0);
        check("s6_base_rst", smz_base, 32'h0000_8000);
        @(negedge clk);
        resetn = 1'b1;
        mem_ready = 1'b1;
        repeat (5) @(negedge clk);
        cfg_read(2'd3, rd); check("s6_status_after", rd, 32'd0);
        check("s6_no_irq", irq_cnt - irq_before, 32'd0);
        check("s6_idle_valid", {31'b0, mem_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
